ecc_scrub_scheduler: RTL

Sequencer for background ECC scrubbing across the protected SRAM banks. It collects the per-bank scrub trigger pulses from the ECC manager and picks one pending bank at a time by round-robin. For that bank it runs a read / check / optional write-back sequence on a single shared scrub port, yielding to functional traffic. It reports every corrected word back to the manager's scrub-fix counters, one pulse per bank.

---
 rtl/ecc_scrub_scheduler.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/ecc_scrub_scheduler.sv
// Background ECC scrub sequencer: round-robin over pending banks, read/check/write-back on a shared port.
// Optional macro ECC_SCRUB_WRITEBACK_EN enables write-back of corrected words; otherwise runs patrol-only.
module ecc_scrub_scheduler #(
    parameter int NumBanks  = 6,
    parameter int AddrWidth = 10,
    parameter int DataWidth = 39,
    localparam int BankWidth = $clog2(NumBanks)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NumBanks-1:0]  scrub_trigger_i,
    input  logic [NumBanks-1:0]  bank_busy_i,
    output logic                 scrub_req_o,
    output logic [BankWidth-1:0] scrub_bank_o,
    output logic [AddrWidth-1:0] scrub_addr_o,
    output logic                 scrub_we_o,
    output logic [DataWidth-1:0] scrub_wdata_o,
    input  logic                 scrub_gnt_i,
    input  logic                 scrub_rvalid_i,
    input  logic [DataWidth-1:0] scrub_rdata_i,
    input  logic [1:0]           scrub_err_i,
    output logic [NumBanks-1:0]  scrub_fix_o,
    output logic [NumBanks-1:0]  scrub_uncorr_o,
    output logic [NumBanks-1:0]  pending_o,
    output logic                 busy_o
);

`ifdef ECC_SCRUB_WRITEBACK_EN
    typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} state_t;
`else
    typedef enum logic [1:0] {IDLE, READ, WAIT} state_t;
`endif

    state_t                     state_reg, state_next;
    logic [NumBanks-1:0]        pending_reg, pending_next;
    logic [BankWidth-1:0]       sel_reg, sel_next;
    logic [BankWidth-1:0]       last_reg, last_next;
    logic [AddrWidth-1:0]       addr_reg, addr_next;
    logic [NumBanks-1:0]        fix_reg, fix_next;
    logic [NumBanks-1:0]        uncorr_reg, uncorr_next;
    logic [NumBanks-1:0]        clear_mask;
    logic [NumBanks-1:0]        sel_onehot;
    logic [NumBanks*AddrWidth-1:0] ptr_flat;
    logic [AddrWidth-1:0]       pick_ptr;
    logic [BankWidth-1:0]       pick;
    logic                       pick_valid;
    logic                       finish;
    logic                       req_active;
    int                         idx;

    // Per-bank word pointers; advance only when that bank's sequence completes.
    for (genvar gi = 0; gi < NumBanks; gi++) begin : g_ptr
        logic [AddrWidth-1:0] ptr_q;
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                ptr_q <= '0;
            end else if (finish && sel_reg == BankWidth'(gi)) begin
                ptr_q <= ptr_q + 1'b1;
            end
        end
        assign ptr_flat[gi*AddrWidth +: AddrWidth] = ptr_q;
    end

    // Scan from farthest to nearest so the first pending bank after last_served wins.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        idx        = 0;
        for (int off = NumBanks; off >= 1; off--) begin
            idx = (int'(last_reg) + off) % NumBanks;
            if (pending_reg[BankWidth'(idx)]) begin
                pick_valid = 1'b1;
                pick       = BankWidth'(idx);
            end
        end
    end

    always_comb begin
        pick_ptr = '0;
        for (int i = 0; i < NumBanks; i++) begin
            if (pick == BankWidth'(i)) pick_ptr = ptr_flat[i*AddrWidth +: AddrWidth];
        end
    end

`ifdef ECC_SCRUB_WRITEBACK_EN
    logic [DataWidth-1:0] wdata_reg, wdata_next;
    assign req_active = (state_reg == READ) || (state_reg == WRITE);
`else
    logic unused_rdata;
    assign unused_rdata = ^scrub_rdata_i;
    assign req_active   = (state_reg == READ);
`endif

    assign scrub_req_o = req_active && !bank_busy_i[sel_reg];

    always_comb begin
        state_next  = state_reg;
        sel_next    = sel_reg;
        addr_next   = addr_reg;
        last_next   = last_reg;
        clear_mask  = '0;
        fix_next    = '0;
        uncorr_next = '0;
        finish      = 1'b0;
        sel_onehot  = NumBanks'(1) << sel_reg;
`ifdef ECC_SCRUB_WRITEBACK_EN
        wdata_next  = wdata_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    sel_next   = pick;
                    addr_next  = pick_ptr;
                    clear_mask = NumBanks'(1) << pick;
                    state_next = READ;
                end
            end
            READ: begin
                if (scrub_req_o && scrub_gnt_i) state_next = WAIT;
            end
            WAIT: begin
                if (scrub_rvalid_i) begin
                    if (scrub_err_i[1]) begin
                        uncorr_next = sel_onehot;
                        finish      = 1'b1;
                    end else if (scrub_err_i[0]) begin
`ifdef ECC_SCRUB_WRITEBACK_EN
                        wdata_next = scrub_rdata_i;
                        state_next = WRITE;
`else
                        fix_next = sel_onehot;
                        finish   = 1'b1;
`endif
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
`ifdef ECC_SCRUB_WRITEBACK_EN
            WRITE: begin
                if (scrub_req_o && scrub_gnt_i) begin
                    fix_next = sel_onehot;
                    finish   = 1'b1;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
        if (finish) begin
            state_next = IDLE;
            last_next  = sel_reg;
        end
        // A trigger coinciding with selection re-arms the bank.
        pending_next = (pending_reg & ~clear_mask) | scrub_trigger_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
            sel_reg     <= '0;
            last_reg    <= BankWidth'(NumBanks - 1);
            addr_reg    <= '0;
            fix_reg     <= '0;
            uncorr_reg  <= '0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            sel_reg     <= sel_next;
            last_reg    <= last_next;
            addr_reg    <= addr_next;
            fix_reg     <= fix_next;
            uncorr_reg  <= uncorr_next;
        end
    end

`ifdef ECC_SCRUB_WRITEBACK_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) wdata_reg <= '0;
        else       wdata_reg <= wdata_next;
    end
    assign scrub_we_o    = (state_reg == WRITE);
    assign scrub_wdata_o = wdata_reg;
`else
    assign scrub_we_o    = 1'b0;
    assign scrub_wdata_o = '0;
`endif

    assign scrub_bank_o   = sel_reg;
    assign scrub_addr_o   = addr_reg;
    assign scrub_fix_o    = fix_reg;
    assign scrub_uncorr_o = uncorr_reg;
    assign pending_o      = pending_reg;
    assign busy_o         = (state_reg != IDLE);

endmodule
